// File: rtl/risc_ctrl_seq_if.sv
// Datapath-side control bundle of the RISC sequencer: instruction/flag/memory
// status in, datapath strobes and status out.
interface risc_ctrl_seq_if;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       carry;
  logic       parity;
  logic       mem_ready;
  logic       ir_load;
  logic       pc_en;
  logic       jmp;
  logic       reg_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] sel;
  logic [3:0] alu_op;
  logic [2:0] flags_q;
  logic       halted;
  logic       mem_err;
  logic [2:0] state_dbg;

  modport master (
    output run, opcode, zero, carry, parity, mem_ready,
    input  ir_load, pc_en, jmp, reg_wr, mem_rd, mem_wr, sel, alu_op,
    input  flags_q, halted, mem_err, state_dbg
  );

  modport slave (
    input  run, opcode, zero, carry, parity, mem_ready,
    output ir_load, pc_en, jmp, reg_wr, mem_rd, mem_wr, sel, alu_op,
    output flags_q, halted, mem_err, state_dbg
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit RISC
// datapath, with latched ALU flags, memory-ready wait/timeout and HALT.
module risc_ctrl_seq #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TIMEOUT_W   = 4,
  parameter bit          RESET_RUN   = 1'b1
) (
  input logic            clk,
  input logic            reset,
  risc_ctrl_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_opc;
  logic [2:0]           r_flags;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_mem_err;
  logic                 r_run_q;
  logic                 w_run_rise;
  logic                 w_mem_to;
  logic                 w_alu_op;

  assign w_run_rise = bus.run & ~r_run_q;
  assign w_mem_to   = (r_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));
  assign w_alu_op   = (r_opc >= 4'h1) && (r_opc <= 4'h8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opc     <= '0;
      r_flags   <= '0;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
      r_run_q   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run_q <= bus.run;
      if (r_state == S_DECODE)
        r_opc <= bus.opcode;
      if (r_state == S_EXEC && w_alu_op)
        r_flags <= {bus.zero, bus.carry, bus.parity};
      if (r_state == S_MEM && !bus.mem_ready) begin
        if (w_mem_to) begin
          r_cnt     <= '0;
          r_mem_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.ir_load   = 1'b0;
    bus.pc_en     = 1'b0;
    bus.jmp       = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.sel       = 2'b00;
    bus.alu_op    = 4'h0;
    bus.halted    = 1'b0;
    case (r_state)
      S_IDLE:   if (RESET_RUN || bus.run) w_next = S_FETCH;
      S_FETCH: begin
        bus.ir_load = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (r_opc)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            bus.alu_op = r_opc;
            w_next     = S_WB;
          end
          4'h9: w_next = S_WB;
          4'hA, 4'hB: begin
            bus.alu_op = 4'h1;
            w_next     = S_MEM;
          end
          4'hC: begin
            bus.pc_en = 1'b1;
            bus.jmp   = 1'b1;
            w_next    = S_FETCH;
          end
          4'hD: begin
            bus.pc_en = 1'b1;
            bus.jmp   = r_flags[2];
            w_next    = S_FETCH;
          end
          4'hE: begin
            bus.pc_en = 1'b1;
            bus.jmp   = r_flags[1];
            w_next    = S_FETCH;
          end
          4'hF: begin
            bus.pc_en = 1'b1;
            w_next    = S_HALT;
          end
          default: begin
            bus.pc_en = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_rd = (r_opc == 4'hA);
        bus.mem_wr = (r_opc == 4'hB);
        // STORE retires in the ready cycle itself, so its pc_en is qualified
        // by mem_ready; every other strobe depends on registered state only.
        bus.pc_en  = (r_opc == 4'hB) & bus.mem_ready;
        if (bus.mem_ready)
          w_next = (r_opc == 4'hA) ? S_WB : S_FETCH;
        else if (w_mem_to)
          w_next = S_HALT;
      end
      S_WB: begin
        bus.reg_wr = 1'b1;
        bus.pc_en  = 1'b1;
        if (r_opc == 4'hA)
          bus.sel = 2'b01;
        else if (r_opc == 4'h9)
          bus.sel = 2'b10;
        w_next = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (w_run_rise && !r_mem_err)
          w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.flags_q   = r_flags;
  assign bus.mem_err   = r_mem_err;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Self-checking bench for risc_ctrl_seq: directed scenarios plus randomized
// instruction streams checked cycle by cycle against per-instruction traces.
module tb_risc_ctrl_seq;
  localparam int MEM_TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  risc_ctrl_seq_if bus ();

  risc_ctrl_seq #(
    .MEM_TIMEOUT(15),
    .TIMEOUT_W  (4),
    .RESET_RUN  (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] m_flags;
  logic       m_err;
  logic [19:0] obs;

  always_comb obs = {bus.state_dbg, bus.halted, bus.mem_err, bus.flags_q,
                     bus.ir_load, bus.pc_en, bus.jmp, bus.reg_wr, bus.mem_rd,
                     bus.mem_wr, bus.sel, bus.alu_op};

  function automatic logic [19:0] pk(input logic [2:0] st, input logic ir,
                                     input logic pc, input logic jm,
                                     input logic rw, input logic mr,
                                     input logic mw, input logic [1:0] sl,
                                     input logic [3:0] ao);
    return {st, st == 3'd6, m_err, m_flags, ir, pc, jm, rw, mr, mw, sl, ao};
  endfunction

  task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_i(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic rand_inputs();
    bus.opcode    = 4'($urandom);
    {bus.zero, bus.carry, bus.parity} = 3'($urandom);
    bus.mem_ready = 1'($urandom);
  endtask

  // Builds the expected cycle trace of one instruction from the opcode rules,
  // then drives it and compares every cycle (stops early after max_cyc).
  task automatic run_instr(input logic [3:0] op, input int waits,
                           input logic [2:0] zcp, input logic run_lvl,
                           input int max_cyc);
    logic [19:0] q[$];
    logic        tmo;
    logic        jm;
    logic        is_mem;
    int          n_mem;
    int          pc_cnt;
    is_mem = (op == 4'hA) || (op == 4'hB);
    tmo    = is_mem && (waits >= MEM_TO);
    pc_cnt = 0;
    q.push_back(pk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    q.push_back(pk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    if (op >= 4'h1 && op <= 4'h8) begin
      q.push_back(pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, op));
      m_flags = zcp;
      q.push_back(pk(3'd5, 0, 1, 0, 1, 0, 0, 2'b00, 4'h0));
    end else if (op == 4'h9) begin
      q.push_back(pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
      q.push_back(pk(3'd5, 0, 1, 0, 1, 0, 0, 2'b10, 4'h0));
    end else if (is_mem) begin
      q.push_back(pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 4'h1));
      n_mem = tmo ? MEM_TO : waits + 1;
      for (int k = 0; k < n_mem; k++)
        q.push_back(pk(3'd4, 0, (op == 4'hB) && !tmo && (k == waits), 0, 0,
                       op == 4'hA, op == 4'hB, 2'b00, 4'h0));
      if (tmo) begin
        m_err = 1'b1;
        q.push_back(pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
      end else if (op == 4'hA) begin
        q.push_back(pk(3'd5, 0, 1, 0, 1, 0, 0, 2'b01, 4'h0));
      end
    end else begin
      jm = (op == 4'hC) ? 1'b1 : (op == 4'hD) ? m_flags[2] :
           (op == 4'hE) ? m_flags[1] : 1'b0;
      q.push_back(pk(3'd3, 0, 1, jm, 0, 0, 0, 2'b00, 4'h0));
      if (op == 4'hF)
        q.push_back(pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    end
    for (int i = 0; i < q.size() && i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      rand_inputs();
      bus.run = run_lvl;
      if (i == 1) bus.opcode = op;
      if (i == 2) {bus.zero, bus.carry, bus.parity} = zcp;
      if (i >= 3 && is_mem) bus.mem_ready = (i == 3 + waits);
      @(negedge clk);
      chk($sformatf("op%0h_cyc%0d", op, i), obs, q[i]);
      chk_i("excl", ($countones({bus.reg_wr, bus.mem_rd, bus.mem_wr}) <= 1) ? 1 : 0, 1);
      pc_cnt += bus.pc_en ? 1 : 0;
    end
    if (max_cyc >= q.size())
      chk_i($sformatf("op%0h_pc_once", op), pc_cnt, tmo ? 0 : 1);
  endtask

  task automatic halt_cycles(input int n, input logic run_lvl);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rand_inputs();
      bus.run = run_lvl;
      @(negedge clk);
      chk("halt_hold", obs, pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    end
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, then
  // releases and checks the IDLE cycle.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    m_flags = '0;
    m_err   = 1'b0;
    chk("reset_async", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_idle", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.carry     = 1'b0;
    bus.parity    = 1'b0;
    bus.mem_ready = 1'b0;
    m_flags       = '0;
    m_err         = 1'b0;
    #20;
    chk("reset_hold", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));

    for (int n = 0; n < 3; n++)
      run_instr(4'h1, 0, 3'($urandom), 1'b0, 99);
    run_instr(4'hA, 2, 3'b000, 1'b0, 99);

    run_instr(4'h2, 0, 3'b100, 1'b0, 99);
    run_instr(4'hD, 0, 3'b000, 1'b0, 99);
    run_instr(4'h2, 0, 3'b011, 1'b0, 99);
    run_instr(4'hD, 0, 3'b000, 1'b0, 99);
    run_instr(4'h1, 0, 3'b010, 1'b0, 99);
    run_instr(4'hE, 0, 3'b000, 1'b0, 99);
    run_instr(4'hC, 0, 3'b000, 1'b0, 99);
    run_instr(4'h9, 0, 3'b000, 1'b0, 99);
    run_instr(4'hB, 1, 3'b000, 1'b0, 99);

    run_instr(4'hF, 0, 3'b000, 1'b1, 99);
    halt_cycles(3, 1'b1);
    halt_cycles(1, 1'b0);
    halt_cycles(1, 1'b1);
    run_instr(4'h0, 0, 3'b000, 1'b0, 99);

    run_instr(4'hB, 99, 3'b000, 1'b0, 99);
    halt_cycles(1, 1'b0);
    halt_cycles(2, 1'b1);
    halt_cycles(1, 1'b0);
    apply_reset();
    run_instr(4'h3, 0, 3'b101, 1'b0, 99);

    run_instr(4'h1, 0, 3'b111, 1'b0, 99);
    run_instr(4'hA, 5, 3'b000, 1'b0, 4);
    apply_reset();
    run_instr(4'hA, 0, 3'b000, 1'b0, 99);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom);
      run_instr(op, int'($urandom_range(0, 4)), 3'($urandom), 1'b0, 99);
      if (op == 4'hF) begin
        halt_cycles(1, 1'b0);
        halt_cycles(1, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
